// File: rtl/seq_stage_controller.sv
// Multi-cycle SEQ sequencer for the Y86 datapath: steps one instruction through
// FETCH..PCUPDATE, drives stage write enables and memory handshakes, owns stat.
module seq_stage_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic [3:0]       icode,
   input  logic             instr_valid,
   output logic             imem_req,
   input  logic             imem_ready,
   input  logic             imem_error,
   output logic             dmem_req,
   output logic             dmem_write,
   input  logic             dmem_ready,
   input  logic             dmem_error,
   output logic             cc_write_enable,
   output logic             regfile_write_enable,
   output logic             pc_write_enable,
   output logic [2:0]       state,
   output logic [2:0]       stat,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retired_count
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_PCUPDATE  = 3'd6,
      S_HALTED    = 3'd7
   } state_t;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   state_t     cur, nxt;
   logic [2:0] stat_q, stat_nxt;
   logic [3:0] icode_q, icode_nxt;
   logic       retire;
   logic       is_mem, is_store, is_wb;

   always_comb begin
      is_mem   = 1'b0;
      is_store = 1'b0;
      is_wb    = 1'b0;
      case (icode_q)
         4'h4, 4'h8, 4'hA: begin is_mem = 1'b1; is_store = 1'b1; end
         4'h5, 4'h9, 4'hB: is_mem = 1'b1;
         default: ;
      endcase
      case (icode_q)
         4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: is_wb = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      nxt       = cur;
      stat_nxt  = stat_q;
      icode_nxt = icode_q;
      retire    = 1'b0;
      case (cur)
         S_IDLE:   if (go) nxt = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               // address fault outranks an illegal-instruction report
               if (imem_error) begin
                  nxt      = S_HALTED;
                  stat_nxt = STAT_ADR;
               end else if (!instr_valid) begin
                  nxt      = S_HALTED;
                  stat_nxt = STAT_INS;
               end else begin
                  icode_nxt = icode;
                  nxt       = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            if (icode_q == 4'h0) begin
               nxt      = S_HALTED;
               stat_nxt = STAT_HLT;
               retire   = 1'b1;
            end else begin
               nxt = S_EXECUTE;
            end
         end
         S_EXECUTE: nxt = S_MEMORY;
         S_MEMORY: begin
            if (!is_mem) begin
               nxt = S_WRITEBACK;
            end else if (dmem_ready) begin
               if (dmem_error) begin
                  nxt      = S_HALTED;
                  stat_nxt = STAT_ADR;
               end else begin
                  nxt = S_WRITEBACK;
               end
            end
         end
         S_WRITEBACK: nxt = S_PCUPDATE;
         S_PCUPDATE: begin
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         default: nxt = S_HALTED;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cur           <= S_IDLE;
         stat_q        <= STAT_AOK;
         icode_q       <= 4'h0;
         cycle_count   <= '0;
         retired_count <= '0;
      end else begin
         cur     <= nxt;
         stat_q  <= stat_nxt;
         icode_q <= icode_nxt;
         if (cur != S_IDLE && cur != S_HALTED) cycle_count <= cycle_count + 1'b1;
         if (retire) retired_count <= retired_count + 1'b1;
      end
   end

   assign state                = cur;
   assign stat                 = stat_q;
   assign imem_req             = (cur == S_FETCH);
   assign dmem_req             = (cur == S_MEMORY) && is_mem;
   assign dmem_write           = (cur == S_MEMORY) && is_store;
   assign cc_write_enable      = (cur == S_EXECUTE) && (icode_q == 4'h6);
   assign regfile_write_enable = (cur == S_WRITEBACK) && is_wb;
   assign pc_write_enable      = (cur == S_PCUPDATE);

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed bench for seq_stage_controller: a per-cycle vector table for two
// back-to-back instructions, then hand-written error, halt and reset sequences.
module tb_seq_stage_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        go;
   logic [3:0]  icode;
   logic        instr_valid;
   logic        imem_req, imem_ready, imem_error;
   logic        dmem_req, dmem_write, dmem_ready, dmem_error;
   logic        cc_write_enable, regfile_write_enable, pc_write_enable;
   logic [2:0]  state, stat;
   logic [31:0] cycle_count, retired_count;

   int total = 0;
   int bad   = 0;
   int cc_n = 0, rf_n = 0, pc_n = 0;

   seq_stage_controller #(.CNT_W(32)) dut (
      .clock(clock), .reset(reset), .go(go), .icode(icode), .instr_valid(instr_valid),
      .imem_req(imem_req), .imem_ready(imem_ready), .imem_error(imem_error),
      .dmem_req(dmem_req), .dmem_write(dmem_write), .dmem_ready(dmem_ready),
      .dmem_error(dmem_error), .cc_write_enable(cc_write_enable),
      .regfile_write_enable(regfile_write_enable), .pc_write_enable(pc_write_enable),
      .state(state), .stat(stat), .cycle_count(cycle_count), .retired_count(retired_count)
   );

   always #5 clock = ~clock;

   // pulse tallies, one count per high cycle
   always @(negedge clock) begin
      if (reset) begin
         if (cc_write_enable)      cc_n <= cc_n + 1;
         if (regfile_write_enable) rf_n <= rf_n + 1;
         if (pc_write_enable)      pc_n <= pc_n + 1;
      end
   end

   typedef struct {
      logic       go;
      logic [3:0] icode;
      logic       ir;
      logic       dr;
      logic [2:0] st;
      logic [5:0] outs;   // {imem_req,dmem_req,dmem_write,cc,rf,pc}
      int         cyc;
      int         ret;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic g, input logic [3:0] ic, input logic ir, input logic dr,
                      input logic [2:0] st, input logic [5:0] outs, input int cyc, input int ret);
      vec_t v;
      v.go = g; v.icode = ic; v.ir = ir; v.dr = dr;
      v.st = st; v.outs = outs; v.cyc = cyc; v.ret = ret;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      go = 0; icode = 4'h1; instr_valid = 1;
      imem_ready = 1; imem_error = 0; dmem_ready = 1; dmem_error = 0;
   endtask

   // leaves the bench 2 time units after a rising edge, DUT in IDLE
   task automatic do_reset();
      idle_inputs();
      reset = 0;
      repeat (2) @(posedge clock);
      #2 reset = 1;
      chk("rst_state", state, 0);
      chk("rst_stat", stat, 1);
      chk("rst_cnt", {cycle_count, retired_count}, 0);
      chk("rst_outs", {imem_req, dmem_req, dmem_write, cc_write_enable,
                       regfile_write_enable, pc_write_enable}, 0);
   endtask

   task automatic wait_state(input string nm, input logic [2:0] tgt, input int max);
      int n = 0;
      while (state !== tgt && n < max) begin
         step();
         n++;
      end
      chk(nm, state, tgt);
   endtask

   int c0, r0, p0, cyc_snap;

   initial begin
      // irmovq then mrmovq with 3 dmem wait cycles; go dropped after leaving IDLE
      add(1, 4'h3, 1, 1, 3'd0, 6'b000000, 0, 0);
      add(0, 4'h3, 1, 1, 3'd1, 6'b100000, 0, 0);
      add(0, 4'h3, 1, 1, 3'd2, 6'b000000, 1, 0);
      add(0, 4'h3, 1, 1, 3'd3, 6'b000000, 2, 0);
      add(0, 4'h3, 1, 1, 3'd4, 6'b000000, 3, 0);
      add(0, 4'h3, 1, 1, 3'd5, 6'b000010, 4, 0);
      add(0, 4'h3, 1, 1, 3'd6, 6'b000001, 5, 0);
      add(0, 4'h5, 1, 1, 3'd1, 6'b100000, 6, 1);
      add(0, 4'h5, 1, 1, 3'd2, 6'b000000, 7, 1);
      add(0, 4'h5, 1, 1, 3'd3, 6'b000000, 8, 1);
      add(0, 4'h5, 1, 0, 3'd4, 6'b010000, 9, 1);
      add(0, 4'h5, 1, 0, 3'd4, 6'b010000, 10, 1);
      add(0, 4'h5, 1, 0, 3'd4, 6'b010000, 11, 1);
      add(0, 4'h5, 1, 1, 3'd4, 6'b010000, 12, 1);
      add(0, 4'h5, 1, 1, 3'd5, 6'b000010, 13, 1);
      add(0, 4'h5, 1, 1, 3'd6, 6'b000001, 14, 1);
      add(0, 4'h5, 1, 1, 3'd1, 6'b100000, 15, 2);

      do_reset();
      r0 = rf_n;
      for (int i = 0; i < vecs.size(); i++) begin
         go = vecs[i].go; icode = vecs[i].icode;
         imem_ready = vecs[i].ir; dmem_ready = vecs[i].dr;
         #1;
         chk($sformatf("v%0d_state", i), state, vecs[i].st);
         chk($sformatf("v%0d_outs", i), {imem_req, dmem_req, dmem_write, cc_write_enable,
                                         regfile_write_enable, pc_write_enable}, vecs[i].outs);
         chk($sformatf("v%0d_stat", i), stat, 1);
         chk($sformatf("v%0d_cyc", i), cycle_count, vecs[i].cyc);
         chk($sformatf("v%0d_ret", i), retired_count, vecs[i].ret);
         step();
      end
      chk("tbl_rf_pulses", rf_n - r0, 2);

      // rmmovq with a data address fault
      do_reset();
      r0 = rf_n; p0 = pc_n;
      go = 1; icode = 4'h4; dmem_error = 1;
      step();
      go = 0;
      repeat (3) step();
      chk("st_mem_write", {state, dmem_req, dmem_write}, {3'd4, 1'b1, 1'b1});
      step();
      chk("st_err_state", state, 7);
      chk("st_err_stat", stat, 3);
      chk("st_err_ret", retired_count, 0);
      step();
      chk("st_err_pulses", {rf_n - r0, pc_n - p0}, 0);

      // OPq then halt; go toggling after halt is ignored
      do_reset();
      c0 = cc_n; p0 = pc_n;
      go = 1; icode = 4'h6;
      step();
      go = 0;
      repeat (6) step();
      chk("op_back_fetch", state, 1);
      icode = 4'h0;
      step();
      chk("halt_decode", state, 2);
      step();
      chk("halt_state", state, 7);
      chk("halt_stat", stat, 2);
      chk("halt_ret", retired_count, 2);
      chk("halt_cyc", cycle_count, 8);
      cyc_snap = cycle_count;
      for (int k = 0; k < 4; k++) begin
         go = k[0];
         step();
      end
      chk("halt_hold", state, 7);
      chk("halt_cyc_frozen", cycle_count, cyc_snap);
      chk("halt_cc_pulses", cc_n - c0, 1);
      chk("halt_pc_pulses", pc_n - p0, 1);

      // fetch fault: address error outranks illegal instruction
      do_reset();
      go = 1; imem_error = 1; instr_valid = 0;
      step();
      step();
      chk("adr_state", state, 7);
      chk("adr_stat", stat, 3);

      // illegal instruction, with two imem wait cycles first
      do_reset();
      go = 1; instr_valid = 0; imem_ready = 0;
      step();
      step();
      chk("ins_wait", {state, imem_req}, {3'd1, 1'b1});
      step();
      chk("ins_wait2", {state, imem_req}, {3'd1, 1'b1});
      imem_ready = 1;
      wait_state("ins_state", 3'd7, 5);
      chk("ins_stat", stat, 4);
      chk("ins_ret", retired_count, 0);

      // reset mid-MEMORY drops dmem_req asynchronously
      do_reset();
      go = 1; icode = 4'h5; dmem_ready = 0;
      step();
      go = 0;
      wait_state("rm_in_mem", 3'd4, 6);
      chk("rm_req_hi", dmem_req, 1);
      #1 reset = 0;
      #1;
      chk("rm_req_lo", {dmem_req, imem_req}, 0);
      chk("rm_state", state, 0);
      chk("rm_stat", stat, 1);
      chk("rm_cnt", {cycle_count, retired_count}, 0);
      step();
      #1 reset = 1;
      icode = 4'h3; dmem_ready = 1; go = 1;
      step();
      go = 0;
      chk("rm_refetch", {state, imem_req}, {3'd1, 1'b1});
      step();
      chk("rm_decode", state, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
